// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and stream framing constants for imem_loader
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/loader_ram.sv
// rtl/loader_ram.sv - word RAM, synchronous write port and combinational read port
module loader_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [31:0]       wd,
    input  logic [ADDR_W-1:0] ra,
    output logic [31:0]       rd
);

    logic [31:0] r_mem [DEPTH];

    // No reset: the image survives a board reset so the CPU can be re-run.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wa] <= wd;
        end
    end

    assign rd = r_mem[ra];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte
module imem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic [31:0] rd,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    loader_state_t              r_state;
    logic [8*LEN_BYTES-1:0]     r_len;
    logic [1:0]                 r_byte_cnt;
    logic [ADDR_W-1:0]          r_word_idx;
    logic [23:0]                r_word_buf;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_error;
    logic                       r_cpu_reset;
    logic [15:0]                r_words_loaded;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]                 r_csum;
`endif

    logic                       w_acc;
    logic                       w_we;
    logic                       w_last_byte;
    logic                       w_last_word;
    logic [8*LEN_BYTES-1:0]     w_len_n;
    logic [31:0]                w_wd;
    logic                       w_unused_a;

    assign in_ready    = (r_state == LEN0) || (r_state == LEN1) ||
                         (r_state == DATA) || (r_state == CSUM);
    assign w_acc       = in_valid & in_ready;
    assign w_len_n     = {in_data, r_len[7:0]};
    assign w_last_byte = (r_byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign w_last_word = ((r_words_loaded + 16'd1) == r_len);
    // Earlier bytes are shifted in from the top, so the buffer holds {b2,b1,b0}.
    assign w_wd        = {in_data, r_word_buf};
    assign w_we        = (r_state == DATA) & w_acc & w_last_byte & ~start;
    assign w_unused_a  = ^{a[31:ADDR_W+2], a[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_len          <= '0;
            r_byte_cnt     <= '0;
            r_word_idx     <= '0;
            r_word_buf     <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_cpu_reset    <= 1'b1;
            r_words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum         <= '0;
`endif
        end else if (start) begin
            r_state        <= LEN0;
            r_byte_cnt     <= '0;
            r_word_idx     <= '0;
            r_word_buf     <= '0;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_cpu_reset    <= 1'b1;
            r_words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum         <= '0;
`endif
        end else if (w_acc) begin
            case (r_state)
                LEN0: begin
                    r_len[7:0] <= in_data;
                    r_state    <= LEN1;
                end
                LEN1: begin
                    r_len <= w_len_n;
                    if (w_len_n == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_state     <= CSUM;
`else
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_cpu_reset <= 1'b0;
`endif
                    end else if (w_len_n > 16'(DEPTH)) begin
                        r_state <= ERR;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_csum <= r_csum ^ in_data;
`endif
                    r_word_buf <= {in_data, r_word_buf[23:8]};
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    if (w_last_byte) begin
                        r_word_idx     <= r_word_idx + 1'b1;
                        r_words_loaded <= r_words_loaded + 16'd1;
                        if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state     <= CSUM;
`else
                            r_state     <= DONE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    r_busy <= 1'b0;
                    if (in_data == r_csum) begin
                        r_state     <= DONE;
                        r_done      <= 1'b1;
                        r_cpu_reset <= 1'b0;
                    end else begin
                        r_state <= ERR;
                        r_error <= 1'b1;
                    end
                end
`endif
                default: r_state <= r_state;
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign cpu_reset    = r_cpu_reset;
    assign words_loaded = r_words_loaded;

    loader_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk (clk),
        .we  (w_we),
        .wa  (r_word_idx),
        .wd  (w_wd),
        .ra  (a[ADDR_W+1:2]),
        .rd  (rd)
    );

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a word-image model
module tb_imem_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [31:0] a = 32'h0;
    logic [31:0] rd;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_ram   [DEPTH];
    bit          exp_known [DEPTH];

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .a            (a),
        .rd           (rd),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input bit e_ready, input bit e_cpu_rst,
                               input bit e_busy, input bit e_done, input bit e_err,
                               input int e_words);
        check({tag, ".in_ready"},     32'(in_ready),     32'(e_ready));
        check({tag, ".cpu_reset"},    32'(cpu_reset),    32'(e_cpu_rst));
        check({tag, ".busy"},         32'(busy),         32'(e_busy));
        check({tag, ".done"},         32'(done),         32'(e_done));
        check({tag, ".error"},        32'(error),        32'(e_err));
        check({tag, ".words_loaded"}, 32'(words_loaded), 32'(e_words));
    endtask

    // Reads every word the model knows, with random junk in the ignored address bits.
    task automatic verify_ram(input string tag);
        logic [31:0] addr;
        for (int i = 0; i < DEPTH; i++) begin
            if (exp_known[i]) begin
                addr = $urandom;
                addr[ADDR_W+1:2] = ADDR_W'(i);
                a = addr;
                #1;
                check($sformatf("%s.ram[%0d]", tag, i), rd, exp_ram[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // idle < 0 selects a random 0..2 idle cycles before the byte.
    task automatic send_byte(input logic [7:0] b, input int idle);
        int n_idle;
        int t;
        n_idle = (idle < 0) ? int'($urandom_range(2)) : idle;
        in_valid = 1'b0;
        repeat (n_idle) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        else @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Sends a whole image and checks the outcome the stream rules dictate.
    task automatic run_load(input string tag, input logic [31:0] w[$], input int n,
                            input int idle, input logic [7:0] csum_flip, input bit do_start);
        logic [31:0] cw;
        logic [7:0]  cs;
        bit          ok;
        logic [15:0] nn;
        if (do_start) begin
            pulse_start();
            check_flags({tag, ".start"}, 1, 1, 1, 0, 0, 0);
        end
        nn = 16'(n);
        send_byte(nn[7:0], idle);
        send_byte(nn[15:8], idle);
        if (n > DEPTH) begin
            check_flags({tag, ".ovf"}, 0, 1, 0, 0, 1, 0);
            repeat (4) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b0;
            check_flags({tag, ".ovf_after"}, 0, 1, 0, 0, 1, 0);
        end else begin
            cs = 8'h00;
            for (int k = 0; k < n; k++) begin
                cw = w[k];
                for (int b = 0; b < 4; b++) begin
                    cs = cs ^ cw[8*b +: 8];
                    send_byte(cw[8*b +: 8], idle);
                end
                exp_ram[k]   = cw;
                exp_known[k] = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(cs ^ csum_flip, idle);
            ok = (csum_flip == 8'h00);
`else
            ok = 1'b1;
`endif
            check_flags({tag, ".end"}, 0, !ok, 0, ok, !ok, n);
        end
        verify_ram(tag);
    endtask

    logic [31:0] img1[$];
    logic [31:0] img7[$];
    logic [31:0] rnd[$];
    logic [31:0] none[$];

    initial begin
        img1 = '{32'hE04F000F, 32'hE2802005};
        img7 = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        for (int i = 0; i < DEPTH; i++) exp_known[i] = 1'b0;

        #3 reset_n = 1'b0;
        @(negedge clk);
        check_flags("reset", 0, 1, 0, 0, 0, 0);
        reset_n = 1'b1;

        run_load("t1", img1, 2, 0, 8'h00, 1);
        run_load("t2", none, 0, 0, 8'h00, 1);
        run_load("t3", none, 65, 0, 8'h00, 1);

        for (int i = 0; i < DEPTH; i++) exp_known[i] = 1'b0;
        exp_ram[0] = 32'h0; exp_ram[1] = 32'h0;
        run_load("t4", '{32'h0, 32'h0}, 2, 0, 8'h00, 1);
        run_load("t4", img1, 2, 1, 8'h00, 1);
        a = 32'h4;
        #1 check("t4.rd_a4", rd, 32'hE2802005);
        @(negedge clk);

        // Reset mid-stream: image word 0 already written must survive.
        run_load("t5pre", '{32'h0}, 1, 0, 8'h00, 1);
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h0F, 0); send_byte(8'h00, 0); send_byte(8'h4F, 0); send_byte(8'hE0, 0);
        exp_ram[0] = 32'hE04F000F;
        check("t5.words_mid", 32'(words_loaded), 32'd1);
        reset_n = 1'b0;
        #1 check_flags("t5.reset", 0, 1, 0, 0, 0, 0);
        verify_ram("t5.reset");
        reset_n = 1'b1;
        run_load("t5", img1, 2, 0, 8'h00, 1);

        // Restart mid-DATA, with a byte offered in the same cycle as start.
        pulse_start();
        send_byte(8'h03, 0); send_byte(8'h00, 0);
        for (int b = 0; b < 4; b++) send_byte(8'(8'hA0 + b), 0);
        exp_ram[0] = 32'hA3A2A1A0;
        send_byte(8'hB0, 0); send_byte(8'hB1, 0);
        check("t7.words_mid", 32'(words_loaded), 32'd1);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check_flags("t7.restart", 1, 1, 1, 0, 0, 0);
        run_load("t7", img7, 3, 0, 8'h00, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        run_load("t6ok",  '{32'h04030201}, 1, 0, 8'h00, 1);
        run_load("t6bad", '{32'h04030201}, 1, 0, 8'h01, 1);
        run_load("t6zero", none, 0, 0, 8'h00, 1);
`endif

        for (int it = 0; it < 15; it++) begin
            int n;
            logic [7:0] flip;
            n = ($urandom_range(7) == 0) ? int'($urandom_range(300, 65)) : int'($urandom_range(DEPTH));
            rnd.delete();
            for (int k = 0; k < n && k < DEPTH; k++) rnd.push_back($urandom);
            flip = ($urandom_range(3) == 0) ? 8'(1 + $urandom_range(254)) : 8'h00;
            run_load($sformatf("rnd%0d", it), rnd, n, -1, flip, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
